// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage issue controller for the HI/LO multiply-divide unit
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MdReq,
  input  logic [2:0]  MdFunc,
  input  logic [31:0] RsVal,
  input  logic [31:0] RtVal,
  input  logic        Flush,
  input  logic        MdBusy,
  input  logic [31:0] HiIn,
  input  logic [31:0] LoIn,
  output logic        MdStart,
  output logic [1:0]  MdOp,
  output logic        MdWe,
  output logic        MdHiLo,
  output logic [31:0] MdD1,
  output logic [31:0] MdD2,
  output logic        Stall,
  output logic [31:0] MfVal
);

  // Counter reload values: RUN lasts exactly N cycles after the start cycle.
  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        inflight;
  logic        accept;
  logic        is_start_cls;
  logic        is_mt_cls;
  logic        is_mf_cls;
  logic        is_div;

  // Instruction class decode and issue qualification.
  always_comb begin
    is_start_cls = (MdFunc[2] == 1'b0);
    is_mt_cls    = (MdFunc[2:1] == 2'b10);
    is_mf_cls    = (MdFunc[2:1] == 2'b11);
    is_div       = (MdFunc[2:1] == 2'b01);
    // Our own RUN state covers the gap before multDiv raises Busy;
    // Busy covers any tail beyond our count and the post-reset window.
    inflight     = (state_q == S_RUN) || MdBusy;
    accept       = MdReq && !inflight && !Flush && !Rst;
  end

  // Drive multDiv controls, pipeline stall and the mf read-back value.
  always_comb begin
    MdStart = 1'b0;
    MdOp    = 2'b00;
    MdWe    = 1'b0;
    MdHiLo  = 1'b0;
    MdD1    = 32'h0;
    MdD2    = 32'h0;
    Stall   = 1'b0;
    MfVal   = 32'h0;
    if (!Rst) begin
      // A cancelled instruction must not freeze the pipe behind it.
      Stall = MdReq && inflight && !Flush;
      if (MdReq) begin
        if (is_start_cls) begin
          MdStart = accept;
          MdOp    = MdFunc[1:0];
          MdD1    = RsVal;
          MdD2    = RtVal;
        end else if (is_mt_cls) begin
          MdWe   = accept;
          MdHiLo = ~MdFunc[0];
          MdD1   = RsVal;
        end else if (is_mf_cls && accept) begin
          MfVal = MdFunc[0] ? LoIn : HiIn;
        end
      end
    end
  end

  // Next-state logic for the busy-window tracker.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Only mult/div open a window; mt/mf complete in the issue cycle.
        if (accept && is_start_cls) begin
          state_d = S_RUN;
          cnt_d   = is_div ? DIV_LAST : MULT_LAST;
        end
      end
      S_RUN: begin
        // Flush is ignored here: multDiv cannot abort, so neither do we.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register; reset abandons tracking and relies on MdBusy afterwards.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - directed self-checking bench for md_issue_ctrl
module tb_md_issue_ctrl;

  localparam logic [2:0] F_MULT  = 3'b000;
  localparam logic [2:0] F_DIV   = 3'b010;
  localparam logic [2:0] F_DIVU  = 3'b011;
  localparam logic [2:0] F_MTHI  = 3'b100;
  localparam logic [2:0] F_MTLO  = 3'b101;
  localparam logic [2:0] F_MFHI  = 3'b110;
  localparam logic [2:0] F_MFLO  = 3'b111;

  localparam logic [31:0] HI_V = 32'hAAAA_0001;
  localparam logic [31:0] LO_V = 32'h5555_0002;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MdReq;
  logic [2:0]  MdFunc;
  logic [31:0] RsVal, RtVal;
  logic        Flush;
  logic        MdBusy;
  logic [31:0] HiIn, LoIn;
  logic        MdStart;
  logic [1:0]  MdOp;
  logic        MdWe;
  logic        MdHiLo;
  logic [31:0] MdD1, MdD2;
  logic        Stall;
  logic [31:0] MfVal;

  int errors = 0;
  int checks = 0;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Rst(Rst), .MdReq(MdReq), .MdFunc(MdFunc),
    .RsVal(RsVal), .RtVal(RtVal), .Flush(Flush), .MdBusy(MdBusy),
    .HiIn(HiIn), .LoIn(LoIn),
    .MdStart(MdStart), .MdOp(MdOp), .MdWe(MdWe), .MdHiLo(MdHiLo),
    .MdD1(MdD1), .MdD2(MdD2), .Stall(Stall), .MfVal(MfVal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle by #1.
  task automatic step(input logic rst, input logic req, input logic [2:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic fl, input logic busy);
    @(negedge Clk);
    Rst = rst; MdReq = req; MdFunc = fn; RsVal = rs; RtVal = rt;
    Flush = fl; MdBusy = busy;
    #1;
  endtask

  initial begin
    Rst = 1'b1; MdReq = 1'b0; MdFunc = 3'b000; RsVal = 32'h0; RtVal = 32'h0;
    Flush = 1'b0; MdBusy = 1'b0; HiIn = HI_V; LoIn = LO_V;

    // Reset with a pending mult: every output held at zero.
    step(1, 1, F_MULT, 32'h11, 32'h22, 0, 0);
    chk("rst_start", 32'(MdStart), 32'd0);
    chk("rst_d1",    MdD1,         32'd0);
    chk("rst_d2",    MdD2,         32'd0);
    chk("rst_stall", 32'(Stall),   32'd0);
    step(1, 1, F_MFLO, 32'h11, 32'h22, 0, 0);
    chk("rst_mfval", MfVal,        32'd0);

    // No request: operand/op buses are zero.
    step(0, 0, F_DIVU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0);
    chk("idle_op", 32'(MdOp), 32'd0);
    chk("idle_d1", MdD1,      32'd0);
    chk("idle_d2", MdD2,      32'd0);

    // mult then back-to-back mflo: 5 stall cycles, accept on the 6th.
    step(0, 1, F_MULT, 32'h0000_0003, 32'hFFFF_FFFE, 0, 0);
    chk("mult_start", 32'(MdStart), 32'd1);
    chk("mult_op",    32'(MdOp),    32'd0);
    chk("mult_d1",    MdD1,         32'h0000_0003);
    chk("mult_d2",    MdD2,         32'hFFFF_FFFE);
    chk("mult_stall", 32'(Stall),   32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
      chk($sformatf("mult_run_stall%0d", i), 32'(Stall), 32'd1);
      chk($sformatf("mult_run_mf%0d", i),    MfVal,      32'd0);
    end
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("mult_done_stall", 32'(Stall), 32'd0);
    chk("mult_done_mflo",  MfVal,      LO_V);

    // divu then mfhi: exactly 10 stall cycles.
    step(0, 1, F_DIVU, 32'hFFFF_FF41, 32'h0000_0025, 0, 0);
    chk("divu_start", 32'(MdStart), 32'd1);
    chk("divu_op",    32'(MdOp),    32'd3);
    chk("divu_d1",    MdD1,         32'hFFFF_FF41);
    chk("divu_d2",    MdD2,         32'h0000_0025);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, F_MFHI, 32'h0, 32'h0, 0, 0);
      chk($sformatf("divu_run_stall%0d", i), 32'(Stall), 32'd1);
    end
    step(0, 1, F_MFHI, 32'h0, 32'h0, 0, 0);
    chk("divu_done_stall", 32'(Stall), 32'd0);
    chk("divu_done_mfhi",  MfVal,      HI_V);

    // mthi / mflo / mtlo direct writes.
    step(0, 1, F_MTHI, 32'h1234_5678, 32'h9999_9999, 0, 0);
    chk("mthi_we",    32'(MdWe),    32'd1);
    chk("mthi_hilo",  32'(MdHiLo),  32'd1);
    chk("mthi_d1",    MdD1,         32'h1234_5678);
    chk("mthi_start", 32'(MdStart), 32'd0);
    chk("mthi_stall", 32'(Stall),   32'd0);
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("mthi_next_mflo",  MfVal,      LO_V);
    chk("mthi_next_stall", 32'(Stall), 32'd0);
    step(0, 1, F_MTLO, 32'h0BAD_F00D, 32'h0, 0, 0);
    chk("mtlo_we",   32'(MdWe),   32'd1);
    chk("mtlo_hilo", 32'(MdHiLo), 32'd0);

    // Flushed div: no start, no stall, no RUN afterwards.
    step(0, 1, F_DIV, 32'h10, 32'h2, 1, 0);
    chk("flush_div_start", 32'(MdStart), 32'd0);
    chk("flush_div_stall", 32'(Stall),   32'd0);
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("flush_div_idle",  32'(Stall),   32'd0);

    // Flush mid-RUN does not abort the window.
    step(0, 1, F_MULT, 32'h5, 32'h6, 0, 0);
    chk("fr_start", 32'(MdStart), 32'd1);
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("fr_t1_stall", 32'(Stall), 32'd1);
    step(0, 1, F_MTHI, 32'h7, 32'h0, 1, 0);
    chk("fr_t2_stall", 32'(Stall), 32'd0);
    chk("fr_t2_we",    32'(MdWe),  32'd0);
    for (int i = 3; i <= 5; i++) begin
      step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
      chk($sformatf("fr_t%0d_stall", i), 32'(Stall), 32'd1);
    end
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("fr_t6_stall", 32'(Stall), 32'd0);

    // Reset during RUN; multDiv Busy blocks issue for 3 more cycles.
    step(0, 1, F_MULT, 32'h3, 32'h4, 0, 0);
    chk("rr_start", 32'(MdStart), 32'd1);
    step(1, 1, F_MULT, 32'h3, 32'h4, 0, 1);
    chk("rr_rst_start", 32'(MdStart), 32'd0);
    chk("rr_rst_op",    32'(MdOp),    32'd0);
    chk("rr_rst_d1",    MdD1,         32'd0);
    chk("rr_rst_stall", 32'(Stall),   32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 1);
      chk($sformatf("rr_busy_stall%0d", i), 32'(Stall), 32'd1);
    end
    step(0, 1, F_MFLO, 32'h0, 32'h0, 0, 0);
    chk("rr_accept_stall", 32'(Stall), 32'd0);
    chk("rr_accept_mflo",  MfVal,      LO_V);

    // Busy outlasts the counter by two cycles; accept when Busy falls.
    step(0, 1, F_MULT, 32'h8, 32'h9, 0, 0);
    chk("bx_start", 32'(MdStart), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, F_MULT, 32'h8, 32'h9, 0, 1);
      chk($sformatf("bx_stall%0d", i), 32'(Stall),   32'd1);
      chk($sformatf("bx_start%0d", i), 32'(MdStart), 32'd0);
    end
    step(0, 1, F_MULT, 32'h8, 32'h9, 0, 0);
    chk("bx_accept_stall", 32'(Stall),   32'd0);
    chk("bx_accept_start", 32'(MdStart), 32'd1);
    step(0, 0, F_MULT, 32'h0, 32'h0, 0, 0);
    chk("bx_noreq_start", 32'(MdStart), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Execute-stage issue controller for the HI/LO multiply-divide unit (`multDiv`).
- Decodes the E-stage mult/div/mthi/mtlo/mfhi/mflo class and drives the unit's `Start`/`Op`/`We`/`HiLo`/`D1`/`D2` inputs.
- Keeps its own latency counter so the busy window is covered from the `Start` cycle onward.
- Raises the pipeline stall for any HI/LO instruction that arrives while an operation is in flight.
- Returns the HI/LO read value for mfhi/mflo.
- Gates all side effects with the exception/interrupt flush.

## Interface
Parameters:
- `MULT_CYCLES`, 5: execution cycles of mult/multu in `multDiv`.
- `DIV_CYCLES`, 10: execution cycles of div/divu in `multDiv`.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `MdReq`  in  1  E-stage holds a valid HI/LO-class instruction.
- `MdFunc`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- `RsVal`, `RtVal`  in  32  forwarded GPR operands.
- `Flush`  in  1  E-stage instruction cancelled this cycle.
- `MdBusy`  in  1  `Busy` from `multDiv`.
- `HiIn`, `LoIn`  in  32  `HI`/`LO` from `multDiv`.
- `MdStart`  out  1  start pulse to `multDiv`.
- `MdOp`  out  2  00 mult, 01 multu, 10 div, 11 divu.
- `MdWe`  out  1  direct HI/LO write (mthi/mtlo).
- `MdHiLo`  out  1  write target: 1 = HI, 0 = LO.
- `MdD1`, `MdD2`  out  32  operands.
- `Stall`  out  1  freeze F/D/E this cycle.
- `MfVal`  out  32  mfhi/mflo result.

## Operation
States and counter:
- Two states: IDLE and RUN. `cnt` is a 4-bit down-counter.
- `inflight = (state==RUN) || MdBusy`.
- `accept = MdReq && !inflight && !Flush && !Rst`.

Outputs (combinational from state and inputs):
- `Stall = MdReq && inflight && !Flush`. Every HI/LO-class op waits, including mthi/mtlo/mfhi/mflo; a flushed instruction never stalls.
- Start class (MdFunc 0xx): `MdStart = accept`, `MdOp = MdFunc[1:0]`, `MdD1 = RsVal`, `MdD2 = RtVal`.
- mthi/mtlo: `MdWe = accept`, `MdHiLo = ~MdFunc[0]`, `MdD1 = RsVal`.
- mfhi/mflo: `MfVal = MdFunc[0] ? LoIn : HiIn`. It is meaningful only when `accept` is high; otherwise 0.
- `MdStart` and `MdWe` are never high together, and never while `Rst`, `Flush` or `inflight` is high.
- With `MdReq` = 0: `MdOp`, `MdD1`, `MdD2` are 0.

Transitions:
- IDLE→RUN on an accepted mult/multu: `cnt <= MULT_CYCLES-1`.
- IDLE→RUN on an accepted div/divu: `cnt <= DIV_CYCLES-1`.
- RUN with `cnt != 0`: `cnt <= cnt-1`.
- RUN with `cnt == 0`: go to IDLE.
- Accepted mthi/mtlo/mfhi/mflo: stay IDLE.

Rules:
- `Flush` does not abort RUN. `multDiv` cannot abort, so an in-flight op completes and later ops still wait for it.
- Divide by zero and signedness are `multDiv`'s concern; this block passes operands unchanged.

## Timing
- Reset:
  - While `Rst` is high: all outputs are 0, state becomes IDLE, `cnt` becomes 0 at the edge.
  - Reset in RUN abandons tracking. `MdBusy` still blocks issue until `multDiv` itself clears.
- Start cycle: `MdStart` is high in cycle T, and `multDiv` samples it at edge T+1.
- RUN window:
  - RUN is occupied for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - A follow-on HI/LO op in cycle T+1 stalls even if `MdBusy` has not yet risen.
  - The earliest next accept is cycle T+N+1, and only if `MdBusy` is low there. `MdBusy` high extends the stall with no upper bound.
- Back-to-back: a mult accepted in cycle T followed immediately by mflo gives `Stall` = 1 for cycles T+1 … T+5 (N = 5); mflo is accepted at T+6 with `MfVal = LoIn`.
- `Flush` and `MdReq` in the same cycle: no start, no write, no stall, no state change.
- `MfVal` reflects HI/LO in the same cycle. A write accepted at T is visible to an mf accepted at T+1 or later.

## Test plan
- mult, `RsVal`=0x0000_0003, `RtVal`=0xFFFF_FFFE, in IDLE → `MdStart`=1, `MdOp`=00 for one cycle; RUN for 5 cycles; IDLE on the 6th.
- divu, `RsVal`=0xFFFF_FF41, `RtVal`=0x25, immediately followed by mfhi → `MdOp`=11; `Stall`=1 for exactly 10 cycles; then `MfVal`=`HiIn` with `Stall`=0.
- mthi, `RsVal`=0x1234_5678, in IDLE → `MdWe`=1, `MdHiLo`=1, `MdD1`=0x1234_5678, no stall; next-cycle mflo → `MfVal`=`LoIn`.
- div with `Flush`=1 in the same cycle → `MdStart`=0, `Stall`=0, state stays IDLE; a flush arriving during RUN leaves the counter running to 0.
- Issue a mult, assert `Rst` for one cycle in RUN with `MdBusy` held high for 3 more cycles → all outputs 0 during reset; a subsequent mflo stalls for those 3 cycles, then is accepted.
- `MdBusy` forced high two cycles past counter expiry → `Stall` persists until `MdBusy` falls; accept occurs in that same cycle.
